// File: rtl/vga_hvsync_if.sv
// vga_hvsync_if: beam position, sync and display-enable bundle from the timing generator to the renderers
interface vga_hvsync_if;
   logic       hsync;
   logic       vsync;
   logic       display_on;
   logic [8:0] hpos;
   logic [8:0] vpos;
   modport master (output hsync, vsync, display_on, hpos, vpos);
   modport slave  (input  hsync, vsync, display_on, hpos, vpos);
endinterface

// File: rtl/vga_hvsync_generator.sv
// vga_hvsync_generator: free-running video timing generator (define HVSYNC_CLKDIV2_EN to advance on every second clk edge)
module vga_hvsync_generator #(
   parameter int H_DISPLAY        = 256,
   parameter int H_BACK           = 23,
   parameter int H_FRONT          = 7,
   parameter int H_SYNC           = 23,
   parameter int V_DISPLAY        = 240,
   parameter int V_TOP            = 5,
   parameter int V_BOTTOM         = 14,
   parameter int V_SYNC           = 3,
   parameter bit SYNC_ACTIVE_HIGH = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   vga_hvsync_if.master vid
);
   localparam int H_MAX_I = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1;
   localparam int V_MAX_I = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1;
   localparam logic [8:0] H_MAX        = 9'(H_MAX_I);
   localparam logic [8:0] V_MAX        = 9'(V_MAX_I);
   localparam logic [8:0] H_SYNC_START = 9'(H_DISPLAY + H_FRONT);
   localparam logic [8:0] H_SYNC_END   = 9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [8:0] V_SYNC_START = 9'(V_DISPLAY + V_BOTTOM);
   localparam logic [8:0] V_SYNC_END   = 9'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
   localparam logic [8:0] H_VIS        = 9'(H_DISPLAY);
   localparam logic [8:0] V_VIS        = 9'(V_DISPLAY);
   localparam logic       ACT          = SYNC_ACTIVE_HIGH;

   // counters are 9 bits wide, so larger timings cannot be represented
   if (H_MAX_I > 511 || V_MAX_I > 511) begin : g_bad_timing
      $error("vga_hvsync_generator: H_MAX/V_MAX exceed 9-bit range");
   end

   logic [8:0] hpos;
   logic [8:0] vpos;
   logic       hsync;
   logic       vsync;
   logic       tick;

`ifdef HVSYNC_CLKDIV2_EN
   logic tog;
   // divide-by-two toggle; tick is high on the first edge after reset release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) tog <= 1'b0;
      else        tog <= ~tog;
   end
   assign tick = ~tog;
`else
   assign tick = 1'b1;
`endif

   // beam counters plus sync outputs registered from the position of the previous tick
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hpos  <= '0;
         vpos  <= '0;
         hsync <= ~ACT;
         vsync <= ~ACT;
      end else if (tick) begin
         hpos  <= (hpos == H_MAX) ? '0 : hpos + 9'd1;
         if (hpos == H_MAX) vpos <= (vpos == V_MAX) ? '0 : vpos + 9'd1;
         hsync <= (hpos >= H_SYNC_START && hpos <= H_SYNC_END) ? ACT : ~ACT;
         vsync <= (vpos >= V_SYNC_START && vpos <= V_SYNC_END) ? ACT : ~ACT;
      end
   end

   assign vid.hpos       = hpos;
   assign vid.vpos       = vpos;
   assign vid.hsync      = hsync;
   assign vid.vsync      = vsync;
   assign vid.display_on = (hpos < H_VIS) && (vpos < V_VIS);
endmodule

// File: tb/tb_vga_hvsync_generator.sv
// tb_vga_hvsync_generator: directed checks of reset, line/frame wrap, sync windows and mid-frame reset
module tb_vga_hvsync_generator;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   cnt, first_on, last_on;

   vga_hvsync_if vid();
   vga_hvsync_generator dut (.clk(clk), .reset(reset), .vid(vid));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // advance n (>0) rising edges since release, then sit on the falling edge
   task automatic adv(input int n);
      repeat (n) begin
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
   endtask

   task automatic go_to(input int t);
      adv(t - cyc);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hpos", 32'(vid.hpos), 0);
      check("rst_vpos", 32'(vid.vpos), 0);
      check("rst_hsync", 32'(vid.hsync), 0);
      check("rst_vsync", 32'(vid.vsync), 0);
      check("rst_don", 32'(vid.display_on), 1);
      reset = 1'b1;
      cyc = 0;
      adv(1); check("rel_h1", 32'(vid.hpos), 1);
      adv(1); check("rel_h2", 32'(vid.hpos), 2);
      adv(1); check("rel_h3", 32'(vid.hpos), 3);
      // reach line 10, hpos 270 (inside hsync) and reset between edges
      go_to(10 * 309 + 270);
      check("mid_hpos", 32'(vid.hpos), 270);
      check("mid_vpos", 32'(vid.vpos), 10);
      check("mid_hsync", 32'(vid.hsync), 1);
      #2 reset = 1'b0;
      #1;
      check("arst_hpos", 32'(vid.hpos), 0);
      check("arst_vpos", 32'(vid.vpos), 0);
      check("arst_hsync", 32'(vid.hsync), 0);
      check("arst_vsync", 32'(vid.vsync), 0);
      check("arst_don", 32'(vid.display_on), 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      cyc = 0;
      adv(1);
      check("restart_hpos", 32'(vid.hpos), 1);
      check("restart_vpos", 32'(vid.vpos), 0);
      go_to(255); check("don_h255", 32'(vid.display_on), 1);
      adv(1);     check("don_h256", 32'(vid.display_on), 0);
      go_to(263); check("hs_h263", 32'(vid.hsync), 0);
      adv(1);     check("hs_h264", 32'(vid.hsync), 1);
      go_to(286); check("hs_h286", 32'(vid.hsync), 1);
      adv(1);     check("hs_h287", 32'(vid.hsync), 0);
      go_to(308);
      check("wrap_pre_h", 32'(vid.hpos), 308);
      check("wrap_pre_v", 32'(vid.vpos), 0);
      adv(1);
      check("wrap_h", 32'(vid.hpos), 0);
      check("wrap_v", 32'(vid.vpos), 1);
      check("wrap_don", 32'(vid.display_on), 1);
      cnt = 0; first_on = -1; last_on = -1;
      repeat (309) begin
         if (vid.hsync) begin
            cnt++;
            if (first_on < 0) first_on = cyc;
            last_on = cyc;
         end
         adv(1);
      end
      check("hs_width", cnt, 23);
      check("hs_first", first_on, 309 + 264);
      check("hs_last", last_on, 309 + 286);
      go_to(74160);
      check("v240_vpos", 32'(vid.vpos), 240);
      check("v240_don", 32'(vid.display_on), 0);
      go_to(78177);
      cnt = 0; first_on = -1; last_on = -1;
      repeat (5 * 309) begin
         if (vid.vsync) begin
            cnt++;
            if (first_on < 0) first_on = cyc;
            last_on = cyc;
         end
         adv(1);
      end
      check("vs_width", cnt, 927);
      check("vs_first", first_on, 78487);
      check("vs_last", last_on, 79413);
      go_to(80957);
      check("fr_pre_h", 32'(vid.hpos), 308);
      check("fr_pre_v", 32'(vid.vpos), 261);
      adv(1);
      check("fr_h", 32'(vid.hpos), 0);
      check("fr_v", 32'(vid.vpos), 0);
      check("fr_don", 32'(vid.display_on), 1);
      check("fr_vsync", 32'(vid.vsync), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
